labsim2_q_monitor: RTL and testbench
====================================

Name: labsim2_q_monitor

Overview:
- Downstream consumer of the pattern-code stage: samples its 8-bit output word `q` every clock.
- Classifies each sample into one of four classes: 0x00, 0x55, 0xFF, or anything else.
- Debounces the class over STABLE_CYC consecutive samples and commits it.
- Reports commit events, per-class commit counts, a sticky illegal-code flag and the run length since the last commit. This gives the bench and the board LEDs a stable status view of the upstream stage.

Parameters:
- STABLE_CYC, 2, consecutive identical-class samples required to commit a class; legal range 1..15.
- CNT_W, 8, width of the commit counters and the run-length counter.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- srst_in  in  1  reset, synchronous, active-high.
- q_in  in  8  code word from the upstream pattern stage.
- cls  out  2  committed class: 00=ZERO (0x00), 01=ALT (0x55), 10=ONES (0xFF), 11=ILLEGAL.
- chg_pulse  out  1  high for exactly one cycle after each commit that changes cls.
- n55  out  CNT_W  number of commits into ALT; saturating.
- nff  out  CNT_W  number of commits into ONES; saturating.
- err  out  1  sticky; set on any commit into ILLEGAL.
- run_len  out  CNT_W  cycles since the last commit; saturating.

Behaviour:
- Raw class is combinational from q_in: exactly 0x00→ZERO, 0x55→ALT, 0xFF→ONES, any other value→ILLEGAL.
- Internal registers:
  - cand (2b): candidate class.
  - stab (4b): consecutive count of cand.
- Update at each edge, given sampled raw class r:
  - r==cand → stab_n = min(stab+1, STABLE_CYC).
  - r!=cand → cand_n = r, stab_n = 1.
- Commit condition: stab_n==STABLE_CYC and cand_n!=cls. On a commit, at the same edge:
  - cls<=cand_n.
  - chg_pulse<=1.
  - run_len<=0.
  - n55 or nff incremented if the new class is ALT or ONES.
  - err<=1 if the new class is ILLEGAL.
- No commit: chg_pulse<=0; run_len<=run_len+1, saturating at all-ones.
- Latency: a class first sampled at edge k, held for STABLE_CYC samples, appears on cls after edge k+STABLE_CYC-1.
  - STABLE_CYC=1 → cls follows q_in class with one cycle of latency.
- Glitch rejection: any run shorter than STABLE_CYC never commits and leaves every output untouched except run_len.
- A stable class equal to cls never re-commits: no pulse, no count change.
- Counters n55, nff and run_len hold at 2^CNT_W-1; they never wrap.
- err clears only on reset; a later commit to another class leaves err=1.
- Reset (srst_in=1 at an edge):
  - cls=00, cand=00, stab=0, chg_pulse=0, n55=0, nff=0, err=0, run_len=0.
  - Reset wins over a simultaneous commit.
  - q_in is ignored during reset.
  - The first post-reset sample counts as stab=1 if its class is ZERO, since cand=ZERO.
- State machine: committed states ZERO/ALT/ONES/ILLEGAL (held in cls).
  - Any state → any other state, only through the commit condition.
  - Self-transition is implicit.
- All outputs are registered.
- q_in is assumed synchronous to clk; no CDC logic.

Test Plan (STABLE_CYC=2, CNT_W=8 unless noted):
1. srst_in=1 for 3 cycles with q_in=0xFF → cls=00, chg_pulse=0, n55=0, nff=0, err=0, run_len=0 throughout; release with q_in=0x00 → no chg_pulse ever; run_len counts 1,2,3...
2. q_in=0x55 for 3 cycles after idle → cls=01 after the 2nd 0x55 edge; chg_pulse high exactly one cycle; n55=1; run_len=0 then 1,2...
3. With cls=01, one-cycle 0xFF glitch then 0x55 → cls stays 01, chg_pulse stays 0, nff=0; run_len keeps incrementing.
4. 0xFF held 2 cycles → cls=10, nff=1; then 0x55 held 2 cycles → cls=01, n55=2; two separate chg_pulse cycles.
5. 0x12 held 2 cycles → cls=11, err=1; then 0x00 held 2 cycles → cls=00, err still 1; n55 and nff unchanged.
6. Repeat 0x55×2 / 0x00×2 for 300 periods → n55 saturates at 0xFF; then 300 cycles of 0x00 → run_len=0xFF held; then srst_in=1 for one edge → all outputs zero on the next cycle.
7. STABLE_CYC=1 build: alternate 0x00/0x55 every cycle → cls toggles every cycle, delayed one cycle; chg_pulse high every cycle.

Source files
------------

// File: rtl/labsim2_q_monitor.sv
// labsim2_q_monitor
// Watches the 8-bit code word from the pattern-code stage and classifies each
// sample as ZERO (0x00), ALT (0x55), ONES (0xFF) or ILLEGAL (anything else).
// A class has to repeat for STABLE_CYC consecutive samples before it is
// committed. The block reports commit events, saturating per-class commit
// counts, a sticky illegal flag and the number of cycles since the last commit.
module labsim2_q_monitor #(
  parameter int STABLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             srst_in,
  input  logic [7:0]       q_in,
  output logic [1:0]       cls,
  output logic             chg_pulse,
  output logic [CNT_W-1:0] n55,
  output logic [CNT_W-1:0] nff,
  output logic             err,
  output logic [CNT_W-1:0] run_len
);

  typedef enum logic [1:0] {
    CLS_ZERO    = 2'b00,
    CLS_ALT     = 2'b01,
    CLS_ONES    = 2'b10,
    CLS_ILLEGAL = 2'b11
  } cls_t;

  localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  cls_t       raw;
  cls_t       cand;
  cls_t       cand_n;
  cls_t       cls_q;
  logic [3:0] stab;
  logic [3:0] stab_n;
  logic       commit;

  // Decode the incoming word into its class; only three exact codes are legal.
  always_comb begin
    raw = CLS_ILLEGAL;
    case (q_in)
      8'h00:   raw = CLS_ZERO;
      8'h55:   raw = CLS_ALT;
      8'hFF:   raw = CLS_ONES;
      default: raw = CLS_ILLEGAL;
    endcase
  end

  // Track the candidate class and how many samples in a row it has been seen.
  always_comb begin
    cand_n = cand;
    stab_n = stab;
    if (raw == cand) begin
      if (stab < STAB_MAX) begin
        stab_n = stab + 4'd1;
      end
    end else begin
      cand_n = raw;
      stab_n = 4'd1;
    end
  end

  // A stable candidate that differs from the committed class is committed now.
  assign commit = (stab_n == STAB_MAX) && (cand_n != cls_q);

  // Debounce registers plus the committed class (the state) and all status outputs.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      cand      <= CLS_ZERO;
      stab      <= 4'd0;
      cls_q     <= CLS_ZERO;
      chg_pulse <= 1'b0;
      n55       <= '0;
      nff       <= '0;
      err       <= 1'b0;
      run_len   <= '0;
    end else begin
      cand <= cand_n;
      stab <= stab_n;
      if (commit) begin
        cls_q     <= cand_n;
        chg_pulse <= 1'b1;
        run_len   <= '0;
        if (cand_n == CLS_ALT && n55 != CNT_MAX) begin
          n55 <= n55 + 1'b1;
        end
        if (cand_n == CLS_ONES && nff != CNT_MAX) begin
          nff <= nff + 1'b1;
        end
        if (cand_n == CLS_ILLEGAL) begin
          err <= 1'b1;
        end
      end else begin
        chg_pulse <= 1'b0;
        if (run_len != CNT_MAX) begin
          run_len <= run_len + 1'b1;
        end
      end
    end
  end

  assign cls = cls_q;

endmodule

// File: tb/tb_labsim2_q_monitor.sv
// Testbench for labsim2_q_monitor.
// Two instances share one stimulus stream: u0 debounces over 2 samples, u1
// over 1 sample. A behavioural model per instance judges commits from the
// recent history of sample classes and is compared every cycle; directed
// literal checks pin the model at key points of each scenario.
module tb_labsim2_q_monitor;

  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             clk;
  logic             srst_in;
  logic [7:0]       q_in;
  logic [1:0]       d_cls     [2];
  logic             d_chg     [2];
  logic [CNT_W-1:0] d_n55     [2];
  logic [CNT_W-1:0] d_nff     [2];
  logic             d_err     [2];
  logic [CNT_W-1:0] d_run     [2];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // model state, one slot per instance
  int m_stable [2] = '{2, 1};
  int m_cls    [2];
  int m_chg    [2];
  int m_n55    [2];
  int m_nff    [2];
  int m_err    [2];
  int m_run    [2];
  int m_seen   [2];
  int m_hist   [2][16];
  bit model_valid = 1'b0;

  labsim2_q_monitor #(.STABLE_CYC(2), .CNT_W(CNT_W)) u0 (
    .clk       (clk),
    .srst_in   (srst_in),
    .q_in      (q_in),
    .cls       (d_cls[0]),
    .chg_pulse (d_chg[0]),
    .n55       (d_n55[0]),
    .nff       (d_nff[0]),
    .err       (d_err[0]),
    .run_len   (d_run[0])
  );

  labsim2_q_monitor #(.STABLE_CYC(1), .CNT_W(CNT_W)) u1 (
    .clk       (clk),
    .srst_in   (srst_in),
    .q_in      (q_in),
    .cls       (d_cls[1]),
    .chg_pulse (d_chg[1]),
    .n55       (d_n55[1]),
    .nff       (d_nff[1]),
    .err       (d_err[1]),
    .run_len   (d_run[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int class_of(input logic [7:0] v);
    if (v == 8'h00) return 0;
    if (v == 8'h55) return 1;
    if (v == 8'hFF) return 2;
    return 3;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a class commits once the last STABLE_CYC samples taken
  // since reset all share it and it differs from the committed class.
  always @(posedge clk) begin
    int r;
    bit all_same;
    r = class_of(q_in);
    for (int i = 0; i < 2; i++) begin
      if (srst_in) begin
        m_cls[i] = 0; m_chg[i] = 0; m_n55[i] = 0; m_nff[i] = 0;
        m_err[i] = 0; m_run[i] = 0; m_seen[i] = 0;
      end else begin
        for (int k = 15; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = r;
        if (m_seen[i] < 100) m_seen[i]++;
        all_same = 1'b1;
        for (int k = 0; k < m_stable[i]; k++) begin
          if (m_hist[i][k] != r) all_same = 1'b0;
        end
        if (m_seen[i] >= m_stable[i] && all_same && r != m_cls[i]) begin
          m_cls[i] = r;
          m_chg[i] = 1;
          m_run[i] = 0;
          if (r == 1 && m_n55[i] < CMAX) m_n55[i]++;
          if (r == 2 && m_nff[i] < CMAX) m_nff[i]++;
          if (r == 3) m_err[i] = 1;
        end else begin
          m_chg[i] = 0;
          if (m_run[i] < CMAX) m_run[i]++;
        end
      end
    end
    model_valid = 1'b1;
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        check_output($sformatf("u%0d.cls", i),       int'(d_cls[i]), m_cls[i]);
        check_output($sformatf("u%0d.chg_pulse", i), int'(d_chg[i]), m_chg[i]);
        check_output($sformatf("u%0d.n55", i),       int'(d_n55[i]), m_n55[i]);
        check_output($sformatf("u%0d.nff", i),       int'(d_nff[i]), m_nff[i]);
        check_output($sformatf("u%0d.err", i),       int'(d_err[i]), m_err[i]);
        check_output($sformatf("u%0d.run_len", i),   int'(d_run[i]), m_run[i]);
      end
    end
  end

  // Hold q/reset for n edges; returns at the negedge after the last edge.
  task automatic apply_stimulus(input logic [7:0] q, input logic rst, input int n);
    for (int c = 0; c < n; c++) begin
      q_in    = q;
      srst_in = rst;
      @(negedge clk);
    end
  endtask

  initial begin
    q_in    = 8'hFF;
    srst_in = 1'b1;

    // 1: reset with q ignored, then idle zeros
    apply_stimulus(8'hFF, 1'b1, 3);
    check_output("t1.cls_rst", int'(d_cls[0]), 0);
    check_output("t1.run_rst", int'(d_run[0]), 0);
    check_output("t1.n55_rst", int'(d_n55[0]), 0);
    apply_stimulus(8'h00, 1'b0, 3);
    check_output("t1.run3", int'(d_run[0]), 3);
    check_output("t1.chg", int'(d_chg[0]), 0);

    // 2: commit to ALT after the second 0x55
    apply_stimulus(8'h55, 1'b0, 1);
    check_output("t2.cls_first", int'(d_cls[0]), 0);
    check_output("t2.run_first", int'(d_run[0]), 4);
    apply_stimulus(8'h55, 1'b0, 1);
    check_output("t2.cls", int'(d_cls[0]), 1);
    check_output("t2.chg", int'(d_chg[0]), 1);
    check_output("t2.n55", int'(d_n55[0]), 1);
    check_output("t2.run0", int'(d_run[0]), 0);
    apply_stimulus(8'h55, 1'b0, 1);
    check_output("t2.chg_low", int'(d_chg[0]), 0);
    check_output("t2.run1", int'(d_run[0]), 1);

    // 3: single-cycle glitch is rejected
    apply_stimulus(8'hFF, 1'b0, 1);
    apply_stimulus(8'h55, 1'b0, 2);
    check_output("t3.cls", int'(d_cls[0]), 1);
    check_output("t3.nff", int'(d_nff[0]), 0);
    check_output("t3.run", int'(d_run[0]), 4);

    // 4: ONES then back to ALT
    apply_stimulus(8'hFF, 1'b0, 2);
    check_output("t4.cls_ones", int'(d_cls[0]), 2);
    check_output("t4.nff", int'(d_nff[0]), 1);
    apply_stimulus(8'h55, 1'b0, 2);
    check_output("t4.cls_alt", int'(d_cls[0]), 1);
    check_output("t4.n55", int'(d_n55[0]), 2);

    // 5: illegal commit sets sticky err
    apply_stimulus(8'h12, 1'b0, 2);
    check_output("t5.cls_ill", int'(d_cls[0]), 3);
    check_output("t5.err", int'(d_err[0]), 1);
    apply_stimulus(8'h00, 1'b0, 2);
    check_output("t5.cls_zero", int'(d_cls[0]), 0);
    check_output("t5.err_sticky", int'(d_err[0]), 1);
    check_output("t5.n55", int'(d_n55[0]), 2);
    check_output("t5.nff", int'(d_nff[0]), 1);

    // 6: saturation of n55 and run_len, then reset
    for (int p = 0; p < 300; p++) begin
      apply_stimulus(8'h55, 1'b0, 2);
      apply_stimulus(8'h00, 1'b0, 2);
    end
    check_output("t6.n55_sat", int'(d_n55[0]), 255);
    check_output("t6.nff", int'(d_nff[0]), 1);
    apply_stimulus(8'h00, 1'b0, 300);
    check_output("t6.run_sat", int'(d_run[0]), 255);
    apply_stimulus(8'h55, 1'b1, 1);
    check_output("t6.cls_rst", int'(d_cls[0]), 0);
    check_output("t6.n55_rst", int'(d_n55[0]), 0);
    check_output("t6.err_rst", int'(d_err[0]), 0);
    check_output("t6.run_rst", int'(d_run[0]), 0);

    // 7: single-sample debounce follows every alternation
    apply_stimulus(8'h00, 1'b0, 1);
    check_output("t7.chg_idle", int'(d_chg[1]), 0);
    for (int c = 0; c < 4; c++) begin
      apply_stimulus(8'h55, 1'b0, 1);
      check_output("t7.cls_alt", int'(d_cls[1]), 1);
      check_output("t7.chg_alt", int'(d_chg[1]), 1);
      apply_stimulus(8'h00, 1'b0, 1);
      check_output("t7.cls_zero", int'(d_cls[1]), 0);
      check_output("t7.chg_zero", int'(d_chg[1]), 1);
    end
    check_output("t7.n55", int'(d_n55[1]), 4);
    check_output("t7.u0_cls", int'(d_cls[0]), 0);

    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
